// File: rtl/anita_scaler_pkg.sv
// Shared constants for the ANITA SURF rate scalers: clock/update rates,
// default widths and the standard prescale settings per channel type.
package anita_scaler_pkg;

  localparam int unsigned CLK_HZ        = 33_000_000;
  localparam int unsigned UPDATE_HZ     = 1000;
  localparam int unsigned DIV_DEFAULT   = CLK_HZ / UPDATE_HZ;
  localparam int unsigned WIDTH_DEFAULT = 16;

  localparam int unsigned PRESCALE_ANTENNA = 8;
  localparam int unsigned PRESCALE_L1      = 4;
  localparam int unsigned PRESCALE_GATED   = 0;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/anita_khz_tick.sv
// Update-tick generator: free-running 0..DIV-1 counter with a registered
// one-cycle tick in the cycle after the counter reaches DIV-1.
module anita_khz_tick
  import anita_scaler_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned           CNT_W = clog2_min1(DIV);
  localparam logic [CNT_W-1:0]      LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_q == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/anita_prescaled_scaler.sv
// Prescaled rate scaler: counts rising edges of count_i / 2^PRESCALE and
// latches the saturating total on each update tick. SCALER_OVERFLOW_FLAG_EN adds overflow_o.
module anita_prescaled_scaler
  import anita_scaler_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEFAULT,
  parameter int unsigned PRESCALE = 0,
  parameter int unsigned DIV      = DIV_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             count_i,
  output logic             khz_clk_o,
  output logic [WIDTH-1:0] scaler_o
`ifdef SCALER_OVERFLOW_FLAG_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int unsigned      PRE_W   = (PRESCALE > 0) ? PRESCALE : 1;
  localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};

  logic             count_q;
  logic             edge_s;
  logic             carry;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] scaler_q, scaler_d;

  anita_khz_tick #(.DIV(DIV)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(khz_clk_o)
  );

  always_comb begin
    edge_s   = count_i & ~count_q;
    carry    = 1'b0;
    pre_d    = pre_q;
    acc_d    = acc_q;
    scaler_d = scaler_q;
    if (khz_clk_o) begin
      // An edge in the tick cycle opens the new interval on a fresh prescaler.
      scaler_d = acc_q;
      pre_d    = (PRESCALE == 0) ? '0 : PRE_W'(edge_s);
      acc_d    = ((PRESCALE == 0) && edge_s) ? WIDTH'(1) : '0;
    end else begin
      if (PRESCALE == 0) begin
        carry = edge_s;
        pre_d = '0;
      end else begin
        carry = edge_s & (&pre_q);
        if (edge_s) pre_d = pre_q + PRE_W'(1);
      end
      if (carry && (acc_q != ACC_MAX)) acc_d = acc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= 1'b0;
      pre_q    <= '0;
      acc_q    <= '0;
      scaler_q <= '0;
    end else begin
      count_q  <= count_i;
      pre_q    <= pre_d;
      acc_q    <= acc_d;
      scaler_q <= scaler_d;
    end
  end

  assign scaler_o = scaler_q;

`ifdef SCALER_OVERFLOW_FLAG_EN
  // The accumulator only grows within an interval, so saturation at the tick
  // means it was reached at some point during that interval.
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (khz_clk_o) overflow_d = (acc_q == ACC_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_anita_prescaled_scaler.sv
// Self-checking bench for anita_prescaled_scaler: three instances with
// different WIDTH/PRESCALE/DIV, an interval-level reference model and directed checks.
module tb_anita_prescaled_scaler;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_bc = 1'b1;
  logic        count_a = 1'b0;
  logic        count_b = 1'b0;
  logic        count_c = 1'b0;
  logic        tick_a, tick_b, tick_c;
  logic [15:0] scaler_a, scaler_b;
  logic [3:0]  scaler_c;
`ifdef SCALER_OVERFLOW_FLAG_EN
  logic        ovf_a, ovf_b, ovf_c;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  anita_prescaled_scaler #(.WIDTH(16), .PRESCALE(0), .DIV(20)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .count_i(count_a),
    .khz_clk_o(tick_a), .scaler_o(scaler_a)
`ifdef SCALER_OVERFLOW_FLAG_EN
    , .overflow_o(ovf_a)
`endif
  );

  anita_prescaled_scaler #(.WIDTH(16), .PRESCALE(2), .DIV(100)) dut_b (
    .clk_i(clk), .rst_i(rst_bc), .count_i(count_b),
    .khz_clk_o(tick_b), .scaler_o(scaler_b)
`ifdef SCALER_OVERFLOW_FLAG_EN
    , .overflow_o(ovf_b)
`endif
  );

  anita_prescaled_scaler #(.WIDTH(4), .PRESCALE(0), .DIV(100)) dut_c (
    .clk_i(clk), .rst_i(rst_bc), .count_i(count_c),
    .khz_clk_o(tick_c), .scaler_o(scaler_c)
`ifdef SCALER_OVERFLOW_FLAG_EN
    , .overflow_o(ovf_c)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: count rising edges per interval as a plain integer, then
  // report floor(edges / 2^PRESCALE) clamped to the counter maximum.
  int div_t[3] = '{20, 100, 100};
  int pre_t[3] = '{0, 2, 0};
  int max_t[3] = '{65535, 65535, 15};
  int m_cyc[3], m_edges[3], m_scaler[3];
  bit m_prev[3], m_tick[3], m_ovf[3], m_valid[3];

  always @(posedge clk) begin : model
    bit r[3];
    bit c[3];
    int e;
    int q;
    r[0] = rst_a;  r[1] = rst_bc;  r[2] = rst_bc;
    c[0] = count_a; c[1] = count_b; c[2] = count_c;
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        m_cyc[i] = 0; m_edges[i] = 0; m_prev[i] = 0;
        m_tick[i] = 0; m_scaler[i] = 0; m_ovf[i] = 0; m_valid[i] = 1;
      end else if (m_valid[i]) begin
        e = (c[i] && !m_prev[i]) ? 1 : 0;
        m_prev[i] = c[i];
        m_cyc[i]++;
        if (m_tick[i]) begin
          q = m_edges[i] >> pre_t[i];
          m_scaler[i] = (q > max_t[i]) ? max_t[i] : q;
          m_ovf[i] = (q >= max_t[i]);
          m_edges[i] = e;
        end else begin
          m_edges[i] += e;
        end
        m_tick[i] = (m_cyc[i] % div_t[i]) == 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_valid[0]) begin
      chk("a_tick", tick_a, m_tick[0]);
      chk("a_scaler", scaler_a, m_scaler[0]);
`ifdef SCALER_OVERFLOW_FLAG_EN
      chk("a_ovf", ovf_a, m_ovf[0]);
`endif
    end
    if (m_valid[1]) begin
      chk("b_tick", tick_b, m_tick[1]);
      chk("b_scaler", scaler_b, m_scaler[1]);
`ifdef SCALER_OVERFLOW_FLAG_EN
      chk("b_ovf", ovf_b, m_ovf[1]);
`endif
    end
    if (m_valid[2]) begin
      chk("c_tick", tick_c, m_tick[2]);
      chk("c_scaler", scaler_c, m_scaler[2]);
`ifdef SCALER_OVERFLOW_FLAG_EN
      chk("c_ovf", ovf_c, m_ovf[2]);
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input int n);
    repeat (n) begin
      count_a = 1'b1; cyc(1);
      count_a = 1'b0; cyc(1);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    cyc(2);
    rst_a = 1'b0;                 // cycle 0 of instance A
    chk("a_reset_scaler", scaler_a, 0);
    chk("a_reset_tick", tick_a, 0);

    for (int c = 1; c <= 61; c++) begin
      cyc(1);
      chk("a_tick_period", tick_a, (c % 20 == 0) ? 1 : 0);
      chk("a_idle_scaler", scaler_a, 0);
    end

    // 7 pulses in cycles 61..74, reported after tick at 80
    pulse_a(7);
    cyc(5);
    chk("a_tick80", tick_a, 1);
    chk("a_before_update", scaler_a, 0);
    cyc(1);
    chk("a_basic7", scaler_a, 7);
    cyc(19);
    chk("a_hold7", scaler_a, 7);
    cyc(1);
    chk("a_empty_interval", scaler_a, 0);

    // edge exactly in tick cycle 120, then two more
    cyc(19);
    chk("a_tick120", tick_a, 1);
    count_a = 1'b1; cyc(1); count_a = 1'b0;
    chk("a_coincide_old", scaler_a, 0);
    cyc(4);
    count_a = 1'b1; cyc(1); count_a = 1'b0; cyc(1);
    count_a = 1'b1; cyc(1); count_a = 1'b0;
    cyc(12);
    chk("a_tick140", tick_a, 1);
    cyc(1);
    chk("a_coincide_new", scaler_a, 3);

    // reset mid-interval
    pulse_a(5);
    chk("a_pre_reset_hold", scaler_a, 3);
    rst_a = 1'b1; cyc(1); rst_a = 1'b0;
    chk("a_midreset_scaler", scaler_a, 0);
    chk("a_midreset_tick", tick_a, 0);
    pulse_a(2);
    cyc(15);
    chk("a_post_reset_tick19", tick_a, 0);
    cyc(1);
    chk("a_post_reset_tick20", tick_a, 1);
    cyc(1);
    chk("a_post_reset_count", scaler_a, 2);

    // instances B (prescale 2) and C (4-bit, saturating)
    rst_bc = 1'b0;                // cycle 0 of B/C
    for (int k = 0; k < 60; k++) begin
      count_c = (k % 2 == 0);
      count_b = (k % 2 == 0) && (k < 20);
      cyc(1);
    end
    count_b = 1'b0; count_c = 1'b0;
    cyc(40);
    chk("b_tick100", tick_b, 1);
    cyc(1);
    chk("b_prescale10", scaler_b, 2);
    chk("c_saturate30", scaler_c, 15);
`ifdef SCALER_OVERFLOW_FLAG_EN
    chk("c_ovf_set", ovf_c, 1);
    chk("b_ovf_clear", ovf_b, 0);
`endif

    count_b = 1'b1;               // held high: a single edge
    for (int k = 0; k < 6; k++) begin
      count_c = (k % 2 == 0);
      cyc(1);
    end
    count_c = 1'b0;
    cyc(94);
    chk("c_after_sat3", scaler_c, 3);
    chk("b_const_high_p2", scaler_b, 0);
`ifdef SCALER_OVERFLOW_FLAG_EN
    chk("c_ovf_cleared", ovf_c, 0);
`endif

    count_c = 1'b1;
    cyc(100);
    chk("c_const_high_p0", scaler_c, 1);
    chk("b_still_zero", scaler_b, 0);

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
